// File: rtl/half_vector_dot_vector_stream.sv
// ---------------------------------------------------------------------------
// half_vector_dot_vector_stream
//
// Streaming binary16 dot-product engine. Each accepted beat carries MULTS
// element pairs; every pair is multiplied and accumulated into its own lane.
// When the vector ends (in_last, or after BEATS beats), the lanes are summed
// one per cycle onto the bias, and the scalar result is held on c until the
// consumer takes it.
//
// Optional feature: define HALF_DOT_RELU_EN to apply ReLU to c (a result with
// the sign bit set is forced to +0). Default build passes the sum unchanged.
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   in_valid   input beat offered
//   in_ready   input beat accepted when in_valid && in_ready
//   in_last    final beat of the current vector
//   vector_a   MULTS lane operands A, lane g at [g*BITS +: BITS]
//   vector_b   MULTS lane operands B, lane g at [g*BITS +: BITS]
//   bias       added to the result, sampled on the first beat of a vector
//   out_valid  result available
//   out_ready  consumer takes result when out_valid && out_ready
//   c          result, 0 whenever out_valid is low
// ---------------------------------------------------------------------------
module half_vector_dot_vector_stream #(
  parameter int BITS   = 16,
  parameter int LENGTH = 10,
  parameter int MULTS  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [MULTS*BITS-1:0]   vector_a,
  input  logic [MULTS*BITS-1:0]   vector_b,
  input  logic [BITS-1:0]         bias,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BITS-1:0]         c
);

  localparam int BEATS  = LENGTH / MULTS;
  localparam int BEAT_W = $clog2(BEATS + 1);
  localparam int RED_W  = (MULTS > 1) ? $clog2(MULTS) : 1;
  localparam logic [15:0] QNAN = 16'h7E00;

  if (BITS != 16) begin : g_bad_bits
    $error("half_vector_dot_vector_stream: BITS must be 16");
  end
  if (MULTS < 1) begin : g_bad_mults
    $error("half_vector_dot_vector_stream: MULTS must be >= 1");
  end
  if ((LENGTH < MULTS) || (LENGTH % MULTS != 0)) begin : g_bad_length
    $error("half_vector_dot_vector_stream: LENGTH must be a multiple of MULTS");
  end

  // -------------------------------------------------------------------------
  // binary16 primitives, round-to-nearest-even, subnormals supported,
  // any NaN result is the canonical quiet NaN 0x7E00.
  // -------------------------------------------------------------------------

  // Round and pack the exact value m * 2^e into binary16.
  function automatic logic [15:0] fp16_pack(input logic s, input int e,
                                            input logic [31:0] m);
    int          k, sh, w, be;
    logic [31:0] keep, rem, tmp;
    logic        g, st;
    logic [15:0] r;
    k = 0;
    for (int i = 0; i < 32; i++) if (m[i]) k = i;
    // Keep 11 significant bits, but never finer than the subnormal LSB 2^-24.
    sh = k - 10;
    if (sh < -24 - e) sh = -24 - e;
    g    = 1'b0;
    st   = 1'b0;
    keep = '0;
    if (sh > 32) begin
      st = (m != 32'd0);
    end else if (sh > 0) begin
      keep = m >> sh;
      tmp  = m >> (sh - 1);
      g    = tmp[0];
      rem  = m & ((32'd1 << (sh - 1)) - 32'd1);
      st   = (rem != 32'd0);
    end else begin
      keep = m << (-sh);
    end
    w = e + sh;
    if (g && (st || keep[0])) keep = keep + 32'd1;
    // Rounding carried out of the significand: renormalise.
    if (keep[11]) begin
      keep = keep >> 1;
      w    = w + 1;
    end
    be = w + 25;
    if (m == 32'd0)    r = {s, 15'd0};
    else if (!keep[10]) r = {s, 5'd0, keep[9:0]};
    else if (be >= 31) r = {s, 5'h1f, 10'd0};
    else               r = {s, be[4:0], keep[9:0]};
    return r;
  endfunction

  function automatic logic [15:0] fp16_mul(input logic [15:0] a,
                                           input logic [15:0] b);
    logic        s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [31:0] ma, mb;
    int          xa, xb;
    logic [15:0] r;
    s      = a[15] ^ b[15];
    a_nan  = (a[14:10] == 5'h1f) && (a[9:0] != 10'd0);
    b_nan  = (b[14:10] == 5'h1f) && (b[9:0] != 10'd0);
    a_inf  = (a[14:10] == 5'h1f) && (a[9:0] == 10'd0);
    b_inf  = (b[14:10] == 5'h1f) && (b[9:0] == 10'd0);
    a_zero = (a[14:0] == 15'd0);
    b_zero = (b[14:0] == 15'd0);
    ma     = {21'd0, (a[14:10] != 5'd0), a[9:0]};
    mb     = {21'd0, (b[14:10] != 5'd0), b[9:0]};
    xa     = (a[14:10] == 5'd0) ? 1 : int'(a[14:10]);
    xb     = (b[14:10] == 5'd0) ? 1 : int'(b[14:10]);
    if (a_nan || b_nan)      r = QNAN;
    else if (a_inf || b_inf) r = (a_zero || b_zero) ? QNAN : {s, 5'h1f, 10'd0};
    else if (a_zero || b_zero) r = {s, 15'd0};
    else                     r = fp16_pack(s, xa + xb - 50, ma * mb);
    return r;
  endfunction

  function automatic logic [15:0] fp16_add(input logic [15:0] a,
                                           input logic [15:0] b);
    logic        sa, sb, ts, a_nan, b_nan, a_inf, b_inf;
    logic [31:0] ma, mb, tm, rem;
    int          xa, xb, tx, d;
    logic [15:0] r;
    sa    = a[15];
    sb    = b[15];
    a_nan = (a[14:10] == 5'h1f) && (a[9:0] != 10'd0);
    b_nan = (b[14:10] == 5'h1f) && (b[9:0] != 10'd0);
    a_inf = (a[14:10] == 5'h1f) && (a[9:0] == 10'd0);
    b_inf = (b[14:10] == 5'h1f) && (b[9:0] == 10'd0);
    // Three extra low bits (guard/round/sticky) make the aligned add exact
    // enough for correct rounding.
    ma    = {18'd0, (a[14:10] != 5'd0), a[9:0], 3'b000};
    mb    = {18'd0, (b[14:10] != 5'd0), b[9:0], 3'b000};
    xa    = (a[14:10] == 5'd0) ? 1 : int'(a[14:10]);
    xb    = (b[14:10] == 5'd0) ? 1 : int'(b[14:10]);
    r     = '0;
    if (a_nan || b_nan)                   r = QNAN;
    else if (a_inf && b_inf && (sa != sb)) r = QNAN;
    else if (a_inf)                       r = a;
    else if (b_inf)                       r = b;
    else begin
      if (xa < xb) begin
        tm = ma; ma = mb; mb = tm;
        tx = xa; xa = xb; xb = tx;
        ts = sa; sa = sb; sb = ts;
      end
      d = xa - xb;
      // Align the smaller operand, folding shifted-out bits into a sticky LSB.
      if (d > 31) begin
        mb = {31'd0, (mb != 32'd0)};
      end else if (d > 0) begin
        rem = mb & ((32'd1 << d) - 32'd1);
        mb  = (mb >> d) | {31'd0, (rem != 32'd0)};
      end
      if (sa == sb)     r = fp16_pack(sa, xa - 28, ma + mb);
      else if (ma > mb) r = fp16_pack(sa, xa - 28, ma - mb);
      else if (mb > ma) r = fp16_pack(sb, xa - 28, mb - ma);
      else              r = 16'h0000;  // exact cancellation is +0
    end
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Datapath and control
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_REDUCE, S_OUT} state_t;

  state_t            state;
  logic [BEAT_W-1:0] beat_cnt;
  logic [RED_W-1:0]  red_cnt;
  logic [BITS-1:0]   sum;
  logic [BITS-1:0]   acc  [MULTS];
  logic [BITS-1:0]   prod [MULTS];

  // NOTE: every element is assigned on each pass, so no latch is inferred.
  always_comb begin
    for (int g = 0; g < MULTS; g++)
      prod[g] = fp16_mul(vector_a[g*BITS +: BITS], vector_b[g*BITS +: BITS]);
  end

  // NOTE: state uses non-blocking assignments so every branch sees the
  // values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
      red_cnt  <= '0;
      sum      <= '0;
      // NOTE: the lane accumulators are architectural state with a defined
      // reset value, so this small array is reset rather than left as RAM.
      for (int g = 0; g < MULTS; g++) acc[g] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            for (int g = 0; g < MULTS; g++) acc[g] <= fp16_add(16'h0000, prod[g]);
            sum      <= bias;
            beat_cnt <= BEAT_W'(1);
            red_cnt  <= '0;
            state    <= (in_last || (BEATS == 1)) ? S_REDUCE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            for (int g = 0; g < MULTS; g++) acc[g] <= fp16_add(acc[g], prod[g]);
            beat_cnt <= beat_cnt + 1'b1;
            // beat_cnt counts beats already taken, so BEATS-1 marks the last one.
            if (in_last || (beat_cnt == BEAT_W'(BEATS - 1))) begin
              red_cnt <= '0;
              state   <= S_REDUCE;
            end
          end
        end
        S_REDUCE: begin
          sum     <= fp16_add(sum, acc[red_cnt]);
          red_cnt <= red_cnt + 1'b1;
          if (red_cnt == RED_W'(MULTS - 1)) state <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = ((state == S_IDLE) || (state == S_ACCUM)) && !rst;
  assign out_valid = (state == S_OUT);

`ifdef HALF_DOT_RELU_EN
  assign c = (out_valid && !sum[BITS-1]) ? sum : '0;
`else
  assign c = out_valid ? sum : '0;
`endif

endmodule
